// File: rtl/gx4000_sprite_scheduler.sv
// Per-scanline sprite scheduler: evaluates sprites on hblank, picks up to eight hits,
// fetches their pattern rows into the line buffer and shares the pattern RAM with the CPU.
module gx4000_sprite_scheduler #(
    parameter int unsigned NUM_SPRITES  = 16,
    parameter int unsigned MAX_PER_LINE = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic        hblank_start,
    input  logic [8:0]  vpos_next,
    output logic [3:0]  attr_addr,
    input  logic [8:0]  attr_y,
    input  logic [1:0]  attr_mag,
    output logic [11:0] pat_addr,
    output logic        pat_we,
    output logic [3:0]  pat_wdata,
    input  logic [3:0]  pat_rdata,
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    input  logic [3:0]  cpu_data,
    output logic        cpu_ack,
    output logic        lb_we,
    output logic [2:0]  lb_slot,
    output logic [3:0]  lb_col,
    output logic [3:0]  lb_pix,
    output logic [7:0]  slot_valid,
    output logic [31:0] slot_sprite,
    output logic        line_ready,
    output logic        overflow
);
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned NSLT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FETCH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NSLT_W-1:0]   nslot_q, nslot_d;
    logic [2:0]          fslot_q, fslot_d;
    logic [3:0]          col_q, col_d;
    logic [7:0]          slot_valid_q, slot_valid_d;
    logic [31:0]         slot_sprite_q, slot_sprite_d;
    logic [31:0]         slot_row_q, slot_row_d;
    logic                overflow_q, overflow_d;
    logic                lb_we_q, lb_we_d;
    logic [2:0]          lb_slot_q, lb_slot_d;
    logic [3:0]          lb_col_q, lb_col_d;

    // Y compare: signed distance, scaled down by magnification, must land in 0..15
    logic [9:0] diff_c;
    logic [1:0] shamt_c;
    logic [8:0] scaled_c;
    logic       hit_c;
    logic       restart_c;
    logic       cpu_grant_c;
    logic [2:0] slot_idx_c;

    assign diff_c     = 10'({1'b0, vpos_next}) - 10'({1'b0, attr_y});
    assign shamt_c    = 2'(attr_mag - 2'd1);
    assign scaled_c   = diff_c[8:0] >> shamt_c;
    assign hit_c      = (attr_mag != 2'd0) && !diff_c[9] && (scaled_c < 9'd16);
    assign restart_c  = hblank_start && plus_mode;
    assign slot_idx_c = nslot_q[2:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nslot_d       = nslot_q;
        fslot_d       = fslot_q;
        col_d         = col_q;
        slot_valid_d  = slot_valid_q;
        slot_sprite_d = slot_sprite_q;
        slot_row_d    = slot_row_q;
        overflow_d    = overflow_q;
        lb_we_d       = 1'b0;
        lb_slot_d     = 3'd0;
        lb_col_d      = 4'd0;

        case (state_q)
            S_EVAL: begin
                if (cnt_q != '0 && hit_c) begin
                    if (nslot_q < NSLT_W'(MAX_PER_LINE)) begin
                        slot_valid_d[slot_idx_c]                  = 1'b1;
                        slot_sprite_d[{slot_idx_c, 2'b00} +: 4]   = 4'(cnt_q - 5'd1);
                        slot_row_d[{slot_idx_c, 2'b00} +: 4]      = 4'(scaled_c);
                        nslot_d                                   = nslot_q + 4'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (cnt_q == CNT_W'(NUM_SPRITES)) begin
                    state_d = (nslot_d != '0) ? S_FETCH : S_DONE;
                    fslot_d = 3'd0;
                    col_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FETCH: begin
                lb_we_d   = 1'b1;
                lb_slot_d = fslot_q;
                lb_col_d  = col_q;
                col_d     = col_q + 4'd1;
                if (col_q == 4'd15) begin
                    if (fslot_q == 3'd7 || !slot_valid_q[fslot_q + 3'd1])
                        state_d = S_DONE;
                    else
                        fslot_d = fslot_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // hblank in any state (re)starts evaluation; partial line-buffer writes stand
        if (restart_c) begin
            state_d       = S_EVAL;
            cnt_d         = '0;
            nslot_d       = '0;
            slot_valid_d  = '0;
            slot_sprite_d = '0;
            overflow_d    = 1'b0;
            lb_we_d       = 1'b0;
        end
        if (!plus_mode) begin
            state_d      = S_IDLE;
            slot_valid_d = '0;
            lb_we_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            nslot_q       <= '0;
            fslot_q       <= '0;
            col_q         <= '0;
            slot_valid_q  <= '0;
            slot_sprite_q <= '0;
            slot_row_q    <= '0;
            overflow_q    <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_slot_q     <= '0;
            lb_col_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nslot_q       <= nslot_d;
            fslot_q       <= fslot_d;
            col_q         <= col_d;
            slot_valid_q  <= slot_valid_d;
            slot_sprite_q <= slot_sprite_d;
            slot_row_q    <= slot_row_d;
            overflow_q    <= overflow_d;
            lb_we_q       <= lb_we_d;
            lb_slot_q     <= lb_slot_d;
            lb_col_q      <= lb_col_d;
        end
    end

    // CPU owns the RAM port except while fetching
    assign cpu_grant_c = cpu_req && !reset && (state_q != S_FETCH);

    always_comb begin
        pat_addr = 12'd0;
        if (cpu_grant_c)
            pat_addr = cpu_addr;
        else if (state_q == S_FETCH)
            pat_addr = {slot_sprite_q[{fslot_q, 2'b00} +: 4], slot_row_q[{fslot_q, 2'b00} +: 4], col_q};
    end

    assign pat_we      = cpu_grant_c;
    assign pat_wdata   = cpu_grant_c ? cpu_data : 4'd0;
    assign cpu_ack     = cpu_grant_c;
    assign attr_addr   = (state_q == S_EVAL && cnt_q < CNT_W'(NUM_SPRITES)) ? 4'(cnt_q) : 4'd0;
    assign lb_we       = lb_we_q;
    assign lb_slot     = lb_slot_q;
    assign lb_col      = lb_col_q;
    assign lb_pix      = lb_we_q ? pat_rdata : 4'd0;
    assign slot_valid  = slot_valid_q;
    assign slot_sprite = slot_sprite_q;
    assign overflow    = overflow_q;
    assign line_ready  = (state_q == S_DONE) && !hblank_start && plus_mode && !reset;

endmodule

// File: tb/tb_gx4000_sprite_scheduler.sv
// Scoreboard bench for the sprite scheduler: attribute/pattern RAM models, expected
// line-buffer writes queued from a behavioural model and popped as the DUT writes.
module tb_gx4000_sprite_scheduler;
    logic        clk_sys = 1'b0;
    logic        reset, plus_mode, hblank_start;
    logic [8:0]  vpos_next;
    logic [3:0]  attr_addr;
    logic [8:0]  attr_y;
    logic [1:0]  attr_mag;
    logic [11:0] pat_addr;
    logic        pat_we;
    logic [3:0]  pat_wdata, pat_rdata;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [3:0]  cpu_data;
    logic        cpu_ack, lb_we;
    logic [2:0]  lb_slot;
    logic [3:0]  lb_col, lb_pix;
    logic [7:0]  slot_valid;
    logic [31:0] slot_sprite;
    logic        line_ready, overflow;

    gx4000_sprite_scheduler dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .hblank_start(hblank_start),
        .vpos_next(vpos_next), .attr_addr(attr_addr), .attr_y(attr_y), .attr_mag(attr_mag),
        .pat_addr(pat_addr), .pat_we(pat_we), .pat_wdata(pat_wdata), .pat_rdata(pat_rdata),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .lb_we(lb_we), .lb_slot(lb_slot), .lb_col(lb_col), .lb_pix(lb_pix),
        .slot_valid(slot_valid), .slot_sprite(slot_sprite), .line_ready(line_ready),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    logic [8:0]  ay [16];
    logic [1:0]  am [16];
    logic [3:0]  mem [4096];
    logic [10:0] exp_q [$];
    logic [7:0]  exp_valid;
    logic [31:0] exp_spr;
    logic        exp_ovf;
    int          n_cmp = 0;
    int          n_err = 0;
    int          early_ack;
    logic [17:0] done_cpu;

    always @(posedge clk_sys) begin
        attr_y   <= ay[attr_addr];
        attr_mag <= am[attr_addr];
    end

    always @(posedge clk_sys) begin
        if (pat_we) mem[pat_addr] <= pat_wdata;
        pat_rdata <= mem[pat_addr];
    end

    function automatic logic [3:0] pix_f(input int a);
        return 4'((a * 7) ^ (a >> 4) ^ (a >> 8) ^ 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (lb_we) begin
            if (exp_q.size() == 0) chk("lb_unexpected", 32'(lb_we), 32'd0);
            else chk("lb_write", 32'({lb_slot, lb_col, lb_pix}), 32'(exp_q.pop_front()));
        end
    end

    // Behavioural line model: pushes the first max_w expected writes
    task automatic model_line(input int vpos, input int max_w);
        int ns = 0;
        int pushed = 0;
        exp_valid = '0; exp_spr = '0; exp_ovf = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (am[s] != 0) begin
                int d = vpos - int'(ay[s]);
                int k = int'(am[s]) - 1;
                if (d >= 0 && d < (16 << k)) begin
                    if (ns < 8) begin
                        int row = (d >> k) & 15;
                        exp_valid[ns] = 1'b1;
                        exp_spr[ns*4 +: 4] = 4'(s);
                        for (int c = 0; c < 16; c++) begin
                            if (pushed < max_w)
                                exp_q.push_back({3'(ns), 4'(c), pix_f(s * 256 + row * 16 + c)});
                            pushed++;
                        end
                        ns++;
                    end else exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_slots(input string tag);
        logic [31:0] mask;
        for (int i = 0; i < 8; i++) mask[i*4 +: 4] = {4{exp_valid[i]}};
        chk({tag, "_valid"}, 32'(slot_valid), 32'(exp_valid));
        chk({tag, "_sprite"}, slot_sprite & mask, exp_spr);
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic clear_attrs();
        for (int s = 0; s < 16; s++) begin ay[s] = 9'd0; am[s] = 2'd0; end
    endtask

    task automatic pulse();
        @(negedge clk_sys);
        hblank_start = 1'b1;
        @(posedge clk_sys); #1;
        hblank_start = 1'b0;
    endtask

    // Returns cycles from pulse to line_ready; optionally raises cpu_req at cycle req_at
    task automatic wait_ready(input int req_at, output int n);
        n = 1;
        early_ack = 0;
        done_cpu = '0;
        forever begin
            @(posedge clk_sys); #1;
            n++;
            if (req_at != 0 && n == req_at) begin
                cpu_addr = 12'hF00; cpu_data = 4'h9; cpu_req = 1'b1;
                #1;
            end
            if (line_ready) begin
                done_cpu = {cpu_ack, pat_we, pat_addr, pat_wdata};
                cpu_req = 1'b0;
                break;
            end
            if (cpu_req && cpu_ack) early_ack++;
            if (n > 400) begin
                chk("ready_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int lr;
        reset = 1'b1; plus_mode = 1'b1; hblank_start = 1'b0; vpos_next = '0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
        clear_attrs();
        for (int i = 0; i < 4096; i++) mem[i] = pix_f(i);
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_outs", {attr_addr, pat_addr, pat_we, cpu_ack, lb_we, lb_slot, lb_col, lb_pix,
                         line_ready, overflow}, 32'd0);
        chk("rst_slots", 32'(slot_valid) | slot_sprite, 32'd0);
        @(negedge clk_sys); reset = 1'b0;

        // single sprite, row 5
        ay[3] = 9'd100; am[3] = 2'd1; vpos_next = 9'd105;
        model_line(105, 9999);
        pulse(); wait_ready(0, n);
        chk("t1_latency", 32'(n), 32'd34);
        check_slots("t1");

        // x4 magnification: last row hits, next line misses
        clear_attrs(); ay[0] = 9'd100; am[0] = 2'd3; vpos_next = 9'd163;
        model_line(163, 9999);
        pulse(); wait_ready(0, n);
        chk("t2_row15_latency", 32'(n), 32'd34);
        check_slots("t2a");
        vpos_next = 9'd164; model_line(164, 9999);
        pulse(); wait_ready(0, n);
        chk("t2_miss_latency", 32'(n), 32'd18);
        check_slots("t2b");

        // no wrap past 511; x2 last row
        clear_attrs(); ay[0] = 9'd510; am[0] = 2'd1; vpos_next = 9'd2;
        model_line(2, 9999);
        pulse(); wait_ready(0, n);
        chk("wrap_latency", 32'(n), 32'd18);
        check_slots("wrap");
        clear_attrs(); ay[5] = 9'd200; am[5] = 2'd2; vpos_next = 9'd231;
        model_line(231, 9999);
        pulse(); wait_ready(0, n);
        chk("x2_latency", 32'(n), 32'd34);
        check_slots("x2");

        // overflow: ten x1 hits plus one x2 hit
        clear_attrs();
        for (int s = 0; s < 10; s++) begin ay[s] = 9'(100 - s); am[s] = 2'd1; end
        ay[12] = 9'd90; am[12] = 2'd2; vpos_next = 9'd100;
        model_line(100, 9999);
        pulse(); wait_ready(0, n);
        chk("t3_latency", 32'(n), 32'd146);
        check_slots("t3");

        // CPU stalled during FETCH, granted in DONE
        clear_attrs(); ay[3] = 9'd100; am[3] = 2'd1; vpos_next = 9'd105;
        model_line(105, 9999);
        pulse(); wait_ready(20, n);
        chk("t4_latency", 32'(n), 32'd34);
        chk("t4_no_ack_in_fetch", 32'(early_ack), 32'd0);
        chk("t4_done_grant", 32'(done_cpu), {14'd0, 1'b1, 1'b1, 12'hF00, 4'h9});

        // hblank mid-FETCH aborts after 7 issued columns, one line_ready afterwards
        model_line(105, 7);
        model_line(105, 9999);
        pulse();
        lr = 0;
        repeat (24) begin @(posedge clk_sys); #1; if (line_ready) lr++; end
        pulse(); wait_ready(0, n);
        chk("t5_no_early_ready", 32'(lr), 32'd0);
        chk("t5_latency", 32'(n), 32'd34);
        check_slots("t5");
        @(posedge clk_sys); #1;
        chk("t5_single_ready", 32'(line_ready), 32'd0);

        // reset during EVAL, pending CPU write dropped
        clear_attrs();
        for (int s = 0; s < 10; s++) begin ay[s] = 9'd100; am[s] = 2'd1; end
        vpos_next = 9'd100;
        pulse();
        repeat (6) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b1; cpu_req = 1'b1; cpu_addr = 12'hF02; cpu_data = 4'h3;
        #1;
        chk("t6_rst_cpu_drop", 32'({cpu_ack, pat_we}), 32'd0);
        @(posedge clk_sys); #1;
        chk("t6_rst_outs", {attr_addr, pat_addr, pat_we, cpu_ack, lb_we, lb_slot, lb_col, lb_pix,
                            line_ready, overflow}, 32'd0);
        chk("t6_rst_slots", 32'(slot_valid), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk_sys); reset = 1'b0;

        // plus_mode low: hblank ignored, CPU acked same cycle
        plus_mode = 1'b0;
        pulse();
        lr = 0;
        repeat (40) begin
            @(posedge clk_sys); #1;
            if (line_ready || attr_addr != 4'd0) lr++;
        end
        chk("t6_idle_held", 32'(lr), 32'd0);
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_addr = 12'hF01; cpu_data = 4'h6;
        #1;
        chk("t6_cpu_ack", {14'd0, cpu_ack, pat_we, pat_addr, pat_wdata}, {14'd0, 1'b1, 1'b1, 12'hF01, 4'h6});
        @(posedge clk_sys); #1;
        cpu_req = 1'b0; plus_mode = 1'b1;

        repeat (4) @(posedge clk_sys);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
